divider_52by24: RTL and testbench

Sequential restoring divider that inverts the 24x28 Wallace product path: it takes a 52-bit dividend (normally a 24x28 product) and a 24-bit divisor, and returns a 28-bit quotient and 24-bit remainder. It computes one quotient bit per clock using a start/busy/ready handshake. It sits beside the Wallace multiplier in the arithmetic unit, and the team uses it for round-trip checking of multiplier products.

---
 rtl/divider_52by24.sv | 113 +++++++++++
 tb/tb_divider_52by24.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/divider_52by24.sv
// Restoring divider, 52-bit dividend by 24-bit divisor, one quotient bit per clock.
// Produces a 28-bit quotient and 24-bit remainder, and flags divide-by-zero or quotient overflow.
module divider_52by24 (
    input  logic        clk,
    input  logic        clrn,
    input  logic        start,
    input  logic [51:0] a,
    input  logic [23:0] b,
    output logic [27:0] q,
    output logic [23:0] r,
    output logic        busy,
    output logic        ready,
    output logic        ovf,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [23:0] rem;
    logic [27:0] low;
    logic [23:0] dvs;
    logic [4:0]  count;

    logic        accept;
    logic        ovf_in;
    logic [24:0] t;
    logic        qbit;
    logic [23:0] rem_step;
    logic [27:0] low_step;

    // Handshake: start is taken only in IDLE or DONE. busy marks RUN, and ready is
    // high for the single DONE cycle. q/r/ovf are valid while ready is high and are
    // held afterwards until the next accepted start.
    assign accept = start && (state == IDLE || state == DONE);
    // A quotient fits in 28 bits only if the upper dividend half is below the divisor.
    assign ovf_in = (b == 24'd0) || (a[51:28] >= b);

    // rem < dvs always holds, so the sign of this 25-bit difference decides the quotient bit.
    assign t        = {rem, low[27]} - {1'b0, dvs};
    assign qbit     = ~t[24];
    assign rem_step = qbit ? t[23:0] : {rem[22:0], low[27]};
    assign low_step = {low[26:0], qbit};

    assign busy      = (state == RUN);
    assign ready     = (state == DONE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nx = ovf_in ? DONE : RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (count == 5'd27) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rem   <= 24'd0;
            low   <= 28'd0;
            dvs   <= 24'd0;
            count <= 5'd0;
            q     <= 28'd0;
            r     <= 24'd0;
            ovf   <= 1'b0;
        end else if (accept) begin
            rem   <= a[51:28];
            low   <= a[27:0];
            dvs   <= b;
            count <= 5'd0;
            ovf   <= ovf_in;
            if (ovf_in) begin
                q <= 28'hFFFFFFF;
                r <= 24'd0;
            end
        end else if (state == RUN) begin
            rem   <= rem_step;
            low   <= low_step;
            count <= count + 5'd1;
            // The last step publishes the quotient, which has fully shifted into low.
            if (count == 5'd27) begin
                q   <= low_step;
                r   <= rem_step;
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_divider_52by24.sv
// Directed bench for divider_52by24: product inversion, remainders, overflow,
// start during RUN, asynchronous reset mid-RUN, back-to-back and a short random sweep.
module tb_divider_52by24;

    logic        clk = 1'b0;
    logic        clrn;
    logic        start;
    logic [51:0] a;
    logic [23:0] b;
    logic [27:0] q;
    logic [23:0] r;
    logic        busy;
    logic        ready;
    logic        ovf;
    logic [1:0]  state_dbg;

    int vec_count = 0;
    int err_count = 0;

    divider_52by24 dut (
        .clk       (clk),
        .clrn      (clrn),
        .start     (start),
        .a         (a),
        .b         (b),
        .q         (q),
        .r         (r),
        .busy      (busy),
        .ready     (ready),
        .ovf       (ovf),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_count++;
        assert (obs === exp)
        else begin
            err_count++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents operands with start for one rising edge; returns at the negedge after it.
    task automatic apply(input logic [51:0] av, input logic [23:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ready(output int cyc, output int busy_cyc);
        cyc      = 0;
        busy_cyc = 0;
        while (ready !== 1'b1 && cyc < 200) begin
            if (busy === 1'b1) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) check("ready_timeout", {63'd0, ready}, 64'd1);
    endtask

    task automatic check_done(input string tag, input logic [27:0] eq, input logic [23:0] er,
                              input logic eo);
        check({tag, "_q"}, {36'd0, q}, {36'd0, eq});
        check({tag, "_r"}, {40'd0, r}, {40'd0, er});
        check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
        check({tag, "_busy_at_ready"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic expect_result(input string tag, input logic [51:0] av, input logic [23:0] bv,
                                 input logic [27:0] eq, input logic [23:0] er, input logic eo,
                                 input int ecyc);
        int cyc;
        int bcyc;
        apply(av, bv);
        wait_ready(cyc, bcyc);
        check({tag, "_latency"}, 64'(cyc), 64'(ecyc));
        check({tag, "_busy_cycles"}, 64'(bcyc), 64'(ecyc));
        check_done(tag, eq, er, eo);
        @(negedge clk);
        check({tag, "_ready_pulse"}, {63'd0, ready}, 64'd0);
    endtask

    initial begin
        int          cyc;
        int          bcyc;
        int          extra;
        logic [23:0] rb;
        logic [23:0] rhi;
        logic [27:0] rlo;
        logic [51:0] ra;
        logic [63:0] eq64;
        logic [63:0] er64;

        clrn  = 1'b0;
        start = 1'b0;
        a     = 52'd0;
        b     = 24'd0;
        #1;
        check("reset_q", {36'd0, q}, 64'd0);
        check("reset_r", {40'd0, r}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_ready", {63'd0, ready}, 64'd0);
        check("reset_ovf", {63'd0, ovf}, 64'd0);
        check("reset_state", {62'd0, state_dbg}, 64'd0);
        @(negedge clk);
        clrn = 1'b1;

        // Exact 24x28 product of all-ones operands.
        expect_result("exact", 52'hFFFFFEF000001, 24'hFFFFFF, 28'hFFFFFFF, 24'd0, 1'b0, 28);
        expect_result("small", 52'd100, 24'd7, 28'd14, 24'd2, 1'b0, 28);
        expect_result("rem5", 52'hFFFFFEF000006, 24'hFFFFFF, 28'hFFFFFFF, 24'd5, 1'b0, 28);

        // Overflow paths finish on the accepting edge and never raise busy.
        expect_result("div0", 52'd123, 24'd0, 28'hFFFFFFF, 24'd0, 1'b1, 0);
        expect_result("qovf", 52'h0000010000000, 24'd1, 28'hFFFFFFF, 24'd0, 1'b1, 0);
        expect_result("after_ovf", 52'd1000, 24'd10, 28'd100, 24'd0, 1'b0, 28);

        // A start pulse during RUN must be ignored.
        apply(52'd100, 24'd7);
        repeat (9) @(negedge clk);
        a     = 52'd999;
        b     = 24'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("runstart_busy", {63'd0, busy}, 64'd1);
        wait_ready(cyc, bcyc);
        check("runstart_latency", 64'(cyc), 64'd18);
        check_done("runstart", 28'd14, 24'd2, 1'b0);
        extra = 0;
        repeat (35) begin
            @(negedge clk);
            if (ready === 1'b1) extra++;
        end
        check("runstart_no_second_ready", 64'(extra), 64'd0);

        // Asynchronous reset in the middle of RUN.
        apply(52'd100, 24'd7);
        repeat (11) @(negedge clk);
        #1;
        clrn = 1'b0;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_ready", {63'd0, ready}, 64'd0);
        check("midrst_q", {36'd0, q}, 64'd0);
        check("midrst_r", {40'd0, r}, 64'd0);
        check("midrst_ovf", {63'd0, ovf}, 64'd0);
        check("midrst_state", {62'd0, state_dbg}, 64'd0);
        @(negedge clk);
        clrn = 1'b1;
        expect_result("post_rst", 52'd1000, 24'd10, 28'd100, 24'd0, 1'b0, 28);

        // Back-to-back: new start taken in the DONE cycle; old result held through RUN.
        apply(52'd100, 24'd7);
        wait_ready(cyc, bcyc);
        check("b2b_first_latency", 64'(cyc), 64'd28);
        check_done("b2b_first", 28'd14, 24'd2, 1'b0);
        a     = 52'd7;
        b     = 24'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", {63'd0, busy}, 64'd1);
        check("b2b_hold_q0", {36'd0, q}, 64'd14);
        check("b2b_hold_r0", {40'd0, r}, 64'd2);
        repeat (14) @(negedge clk);
        check("b2b_hold_q14", {36'd0, q}, 64'd14);
        check("b2b_hold_r14", {40'd0, r}, 64'd2);
        wait_ready(cyc, bcyc);
        check("b2b_second_latency", 64'(cyc), 64'd14);
        check_done("b2b_second", 28'd3, 24'd1, 1'b0);

        // Random non-overflow operands checked against a division model.
        for (int i = 0; i < 40; i++) begin
            rb   = 24'($urandom_range(32'hFFFFFF, 1));
            rhi  = 24'($urandom_range(32'(rb) - 1, 0));
            rlo  = 28'($urandom);
            ra   = {rhi, rlo};
            eq64 = {12'd0, ra} / {40'd0, rb};
            er64 = {12'd0, ra} % {40'd0, rb};
            expect_result("rand", ra, rb, eq64[27:0], er64[23:0], 1'b0, 28);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
